// File: rtl/multi_tick_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package multi_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Reset divisor CLK_FREQ/DEFAULT_FREQ, never below 1 so a channel always has a sane period.
    function automatic int unsigned reset_div(input int unsigned clk_freq,
                                              input int unsigned default_freq);
        int unsigned d;
        if (default_freq == 0) begin
            d = 1;
        end else begin
            d = clk_freq / default_freq;
        end
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/multi_tick_gen_channel.sv
// One tick channel: IDLE/RUN/DONE FSM, period counter, pending and active divisors.
module tick_channel
    import multi_tick_pkg::*;
#(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned RST_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic             sync_clr,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    localparam logic [DIV_W-1:0] RST_DIV_W = DIV_W'(RST_DIV);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             tick_d, busy_d, done_d;
    logic [DIV_W-1:0] last_c;
    logic [DIV_W-1:0] load_val;
    logic             run_step;

    // Terminal count N-1, with divisor 0 and 1 both meaning a period of one cycle.
    assign last_c = (act_q <= DIV_W'(1)) ? '0 : act_q - DIV_W'(1);

    // State, counter, divisor and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= RST_DIV_W;
            pend_q  <= RST_DIV_W;
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            tick    <= tick_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, counter and divisor update; the IDLE->RUN edge counts as the first run step.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        run_step = 1'b0;
        load_val = div_load ? div_value : pend_q;

        if (div_load) begin
            pend_d = div_value;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                act_d = load_val;
                if (en && !sync_clr) begin
                    state_d  = RUN;
                    run_step = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (sync_clr) begin
                    cnt_d = '0;
                end else begin
                    run_step = 1'b1;
                end
            end
            DONE: begin
                cnt_d = '0;
                act_d = load_val;
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (run_step) begin
            if (cnt_q == last_c) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                act_d  = load_val;
                if (mode == MODE_ONESHOT) begin
                    state_d = DONE;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: slices divisors and fans out sync_clr.
module multi_tick_gen
    import multi_tick_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned DEFAULT_FREQ = 1,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH*DIV_W-1:0] div_value,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    localparam int unsigned RST_DIV = reset_div(CLK_FREQ, DEFAULT_FREQ);

    // One independent channel per bit of en.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        tick_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[ch]),
            .mode      (mode[ch]),
            .div_load  (div_load[ch]),
            .div_value (div_value[ch*DIV_W +: DIV_W]),
            .sync_clr  (sync_clr),
            .tick      (tick[ch]),
            .busy      (busy[ch]),
            .done      (done[ch])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen (CLK_FREQ=10, DEFAULT_FREQ=2 -> reset divisor 5).
`timescale 1ns/1ps
module tb_multi_tick_gen;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en, mode, div_load;
    logic [NUM_CH*DIV_W-1:0] div_value;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       tick, busy, done;

    always #5 clk = ~clk;

    multi_tick_gen #(
        .CLK_FREQ     (10),
        .DEFAULT_FREQ (2),
        .NUM_CH       (NUM_CH),
        .DIV_W        (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .div_load  (div_load),
        .div_value (div_value),
        .sync_clr  (sync_clr),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] busy;
        logic [NUM_CH-1:0] done;
        string             name;
    } exp_t;

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] mode;
        int                reps;
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] b;
        logic [NUM_CH-1:0] d;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[11];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_out(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] b,
                              input logic [NUM_CH-1:0] d, input string nm);
        exp_t e;
        e.tick = t;
        e.busy = b;
        e.done = d;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = exp_q.pop_front();
            if (tick !== e.tick || busy !== e.busy || done !== e.done) begin
                bad++;
                $display("FAIL %s: got tick=%b busy=%b done=%b, required tick=%b busy=%b done=%b",
                         e.name, tick, busy, done, e.tick, e.busy, e.done);
            end
        end
    endtask

    // Queue the expectation, clock one edge, then compare just after it.
    task automatic step(input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] b,
                        input logic [NUM_CH-1:0] d, input string nm);
        expect_out(t, b, d, nm);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        logic [NUM_CH-1:0] et;

        // ch0 periodic, ch1 one-shot, both enabled at E0; then ch1 re-armed
        tbl[0]  = '{4'b0011, 4'b0010, 4, 4'b0000, 4'b0011, 4'b0000};
        tbl[1]  = '{4'b0011, 4'b0010, 1, 4'b0011, 4'b0001, 4'b0010};
        tbl[2]  = '{4'b0011, 4'b0010, 4, 4'b0000, 4'b0001, 4'b0010};
        tbl[3]  = '{4'b0011, 4'b0010, 1, 4'b0001, 4'b0001, 4'b0010};
        tbl[4]  = '{4'b0011, 4'b0010, 4, 4'b0000, 4'b0001, 4'b0010};
        tbl[5]  = '{4'b0011, 4'b0010, 1, 4'b0001, 4'b0001, 4'b0010};
        tbl[6]  = '{4'b0001, 4'b0010, 1, 4'b0000, 4'b0001, 4'b0000};
        tbl[7]  = '{4'b0011, 4'b0010, 3, 4'b0000, 4'b0011, 4'b0000};
        tbl[8]  = '{4'b0011, 4'b0010, 1, 4'b0001, 4'b0011, 4'b0000};
        tbl[9]  = '{4'b0011, 4'b0010, 1, 4'b0010, 4'b0001, 4'b0010};
        tbl[10] = '{4'b0011, 4'b0010, 1, 4'b0000, 4'b0001, 4'b0010};

        rst_n     = 1'b0;
        en        = '0;
        mode      = '0;
        div_load  = '0;
        div_value = '0;
        sync_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_out(4'b0000, 4'b0000, 4'b0000, "reset_state");
        compare_out();
        rst_n = 1'b1;

        // Table: k = 0..21 edges after E0
        for (int i = 0; i < 11; i++) begin
            en   = tbl[i].en;
            mode = tbl[i].mode;
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].t, tbl[i].b, tbl[i].d, $sformatf("vec%0d_%0d", i, r));
            end
        end

        // Reload ch0 to 3 one edge before its wrap at k24: wraps at 24, then 27, 30
        en   = 4'b0001;
        mode = 4'b0000;
        for (int k = 22; k <= 31; k++) begin
            div_load  = (k == 23) ? 4'b0001 : 4'b0000;
            div_value = (k == 23) ? 32'h0000_0003 : 32'h0000_0000;
            et = (k == 24 || k == 27 || k == 30) ? 4'b0001 : 4'b0000;
            step(et, 4'b0001, 4'b0000, $sformatf("reload_k%0d", k));
        end
        div_load  = '0;
        div_value = '0;

        // Divisor 0 on ch2 while idle, then enable: tick every cycle
        div_load = 4'b0100;
        step(4'b0000, 4'b0001, 4'b0000, "div0_load_k32");
        div_load = '0;
        en       = 4'b0101;
        for (int k = 33; k <= 37; k++) begin
            et = (k == 33 || k == 36) ? 4'b0101 : 4'b0100;
            step(et, 4'b0101, 4'b0000, $sformatf("div0_run_k%0d", k));
        end
        en = 4'b0001;
        step(4'b0000, 4'b0001, 4'b0000, "ch2_off_k38");
        step(4'b0001, 4'b0001, 4'b0000, "ch0_wrap_k39");

        // Asynchronous reset mid-operation while tick[0] is high
        rst_n = 1'b0;
        en    = '0;
        #2;
        expect_out(4'b0000, 4'b0000, 4'b0000, "reset_async");
        compare_out();
        step(4'b0000, 4'b0000, 4'b0000, "reset_hold0");
        step(4'b0000, 4'b0000, 4'b0000, "reset_hold1");
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 4'b0000, "idle_no_en");

        // ch0 then ch3 two edges later at divisor 5; sync_clr on ch0's wrap edge (j=9)
        for (int j = 0; j < 20; j++) begin
            en       = (j >= 2) ? 4'b1001 : 4'b0001;
            sync_clr = (j == 9);
            et = 4'b0000;
            if (j == 4 || j == 14 || j == 19) et[0] = 1'b1;
            if (j == 6 || j == 14 || j == 19) et[3] = 1'b1;
            step(et, (j >= 2) ? 4'b1001 : 4'b0001, 4'b0000, $sformatf("sync_j%0d", j));
        end
        sync_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Multi-channel programmable tick generator. Successor to the fixed single-rate divider.
- Each channel produces 1-cycle tick pulses at a runtime-loadable divisor.
- Each channel runs in periodic or one-shot mode, with per-channel enable and a global phase-sync clear.
- Feeds game timing: LED step rate, input timeout, tone gating, debounce sampling.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- DEFAULT_FREQ, 1, tick rate in Hz for every channel after reset. Reset divisor is CLK_FREQ/DEFAULT_FREQ.
- NUM_CH, 4, number of independent channels (1..16).
- DIV_W, 32, divisor register width. Must hold CLK_FREQ/DEFAULT_FREQ.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  NUM_CH  per-channel run enable, level-sensitive.
- mode  in  NUM_CH  per-channel mode: 0 = periodic, 1 = one-shot.
- div_load  in  NUM_CH  per-channel 1-cycle strobe that loads div_value[ch].
- div_value  in  NUM_CH*DIV_W  packed divisors; channel ch occupies bits [ch*DIV_W +: DIV_W].
- sync_clr  in  1  global phase clear for all channels.
- tick  out  NUM_CH  registered 1-cycle tick pulse.
- busy  out  NUM_CH  channel is in RUN.
- done  out  NUM_CH  one-shot channel has fired and is parked.

Behaviour:
- Reset (async, rst_n=0):
  - tick=0, busy=0, done=0.
  - All counters=0, all states=IDLE.
  - Active and pending divisors = CLK_FREQ/DEFAULT_FREQ.
- Effective period N = active divisor. Divisor 0 or 1 gives N=1 (tick every cycle while running).
- Per-channel FSM, states IDLE / RUN / DONE:
  - IDLE: counter held at 0, tick=0. Goes to RUN on the edge where en=1.
  - RUN:
    - Counter increments each edge.
    - On the edge where counter==N-1: counter<=0 and tick<=1.
    - In mode 0, stay in RUN.
    - In mode 1, go to DONE.
    - en=0 sampled: go to IDLE, counter<=0, no tick that edge.
  - DONE: counter frozen at 0, tick=0, done=1. Goes to IDLE only when en=0; en held high stays in DONE. Re-arm requires en low for at least 1 cycle.
- Latency:
  - Edge E0 is the first edge with en=1 in IDLE (the IDLE->RUN edge); counter becomes 1.
  - First tick is high during the cycle after edge E0+N-1, i.e. N edges after enable.
  - Subsequent ticks every N cycles exactly.
  - N=1: tick high continuously from the cycle after E0.
- Divisor load:
  - div_load[ch] captures div_value slice into the pending register.
  - Pending is copied to active at the next wrap edge, or immediately if the channel is in IDLE/DONE.
  - Load coincident with a wrap: the new value applies to the very next period. The period in progress is never truncated.
- Mode changes while in RUN take effect at the next wrap.
- sync_clr=1:
  - All counters<=0 and ticks<=0 that edge, which overrides a coincident wrap (that tick is suppressed).
  - RUN channels stay RUN; DONE and IDLE states are unchanged.
  - Next tick is N edges after the sync_clr edge, so all equal-divisor channels become phase-aligned.
- Priority per edge: rst_n > en=0 > sync_clr > wrap/increment.
- busy = (state==RUN); done = (state==DONE). Both registered, no combinational path from inputs.
- Counter width = DIV_W, with no overflow. The compare uses active N-1 and is computed with divisor clamping (0 treated as 1).
- Reset mid-operation: immediate return to reset values; pending loads are lost.

Decomposition:
- Package multi_tick_pkg holds:
  - state enum {IDLE, RUN, DONE} (2 bits);
  - mode encodings MODE_PERIODIC=0, MODE_ONESHOT=1;
  - a function computing the clamped reset divisor.
- Sub-module tick_channel (one counter, FSM, pending/active divisor) is instantiated NUM_CH times in a generate loop.
- The top level only slices div_value and fans out sync_clr.

Test Plan:
All scenarios use CLK_FREQ=10, DEFAULT_FREQ=2 (reset divisor 5), NUM_CH=4, DIV_W=8.
- Reset then en[0]=1 (mode 0) held -> tick[0] pulses 1 cycle at edges E0+4, E0+9, E0+14; busy[0]=1; other ticks 0.
- en[1]=1, mode[1]=1 -> single tick[1] at E0+4, then done[1]=1 and no further ticks. Drop en[1] for 1 cycle and raise again -> done clears and a new tick fires 5 edges later.
- Channel 0 running: div_load[0] with value 3 one cycle before a wrap -> current period stays 5; following periods are 3 cycles.
- Load div_value=0 on channel 2, then enable -> tick[2]=1 every cycle.
- Channels 0 and 3 running at divisor 5 with phases offset by 2 -> pulse sync_clr -> coincident wrap suppressed, both tick together 5 edges later and stay aligned.
- Assert rst_n=0 mid-period while running -> tick, busy, done go to 0 immediately. After release, channels need a fresh en to start at divisor 5.
